// File: rtl/dtcm_ctrl_pkg.sv
// dtcm_ctrl_pkg: local types for the data-TCM controller.
// XLEN and DTCM_ADDR_WIDTH normally come from the shared defines.v.
// The fallbacks below apply only when that file has not been preloaded.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif

package dtcm_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } dtcm_state_e;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/dtcm_ctrl_if.sv
// dtcm_ctrl_if: LSU <-> data-TCM command/response channel.
// The master drives commands and rsp_ready. The slave (the TCM) answers.
interface dtcm_ctrl_if #(
  parameter int AW = `DTCM_ADDR_WIDTH
);
  logic                 dtcm_cmd_valid;
  logic                 dtcm_cmd_ready;
  logic                 dtcm_cmd_read;
  logic [AW-1:0]        dtcm_cmd_addr;
  logic [`XLEN-1:0]     dtcm_cmd_wdata;
  logic [`XLEN/8-1:0]   dtcm_cmd_wmask;
  logic                 dtcm_rsp_valid;
  logic                 dtcm_rsp_ready;
  logic [`XLEN-1:0]     dtcm_rsp_rdata;
  logic                 dtcm_rsp_err;

  modport master (
    output dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata,
           dtcm_cmd_wmask, dtcm_rsp_ready,
    input  dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata, dtcm_rsp_err
  );

  modport slave (
    input  dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata,
           dtcm_cmd_wmask, dtcm_rsp_ready,
    output dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata, dtcm_rsp_err
  );
endinterface

// File: rtl/dtcm_ctrl_sram.sv
// sram_1p: single-port synchronous RAM, per-byte write enable,
// registered read (data valid the cycle after en). Contents are not reset.
module sram_1p
  import dtcm_ctrl_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       en_i,
  input  logic [WIDTH/BYTE_W-1:0]    we_i,
  input  logic [$clog2(DEPTH)-1:0]   addr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Byte-masked write and read-before-write registered read on each enabled cycle
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < WIDTH/BYTE_W; b++) begin
        if (we_i[b]) mem_q[addr_i][BYTE_W*b +: BYTE_W] <= wdata_i[BYTE_W*b +: BYTE_W];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dtcm_ctrl.sv
// dtcm_ctrl: data-TCM controller with one response outstanding.
// The RAM is accessed on the command handshake. The response follows one cycle later.
// Optional: define DTCM_ADDR_CHK_EN to flag word indices >= DP with
// dtcm_rsp_err and block the write. Without it, the index wraps modulo DP.
//
//   state   | meaning
//   --------+-------------------------------------------
//   ST_IDLE | no response held, command always accepted
//   ST_RSP  | response presented, held until rsp_ready
module dtcm_ctrl
  import dtcm_ctrl_pkg::*;
#(
  parameter int DP = 1024,
  parameter int AW = `DTCM_ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  dtcm_ctrl_if.slave  bus
);
  localparam int IDX_W = $clog2(DP);

  dtcm_state_e        state_q, state_d;
  logic               rsp_read_q, rsp_read_d;
  logic               rsp_err_q, rsp_err_d;
  logic               cmd_fire;
  logic               addr_err;
  logic [AW-3:0]      word_idx;
  logic [`XLEN/8-1:0] ram_we;
  logic [`XLEN-1:0]   ram_rdata;

  assign word_idx = bus.dtcm_cmd_addr[AW-1:2];
  assign cmd_fire = bus.dtcm_cmd_valid & bus.dtcm_cmd_ready;

`ifdef DTCM_ADDR_CHK_EN
  logic unused_addr;
  assign addr_err    = (32'(word_idx) >= 32'(DP));
  assign unused_addr = ^bus.dtcm_cmd_addr[1:0];
`else
  logic unused_addr;
  assign addr_err    = 1'b0;
  assign unused_addr = ^{bus.dtcm_cmd_addr[1:0], word_idx};
`endif

  // Writes are suppressed for loads and for out-of-range stores
  assign ram_we = (cmd_fire && !bus.dtcm_cmd_read && !addr_err) ? bus.dtcm_cmd_wmask : '0;

  sram_1p #(
    .DEPTH (DP),
    .WIDTH (`XLEN)
  ) u_sram (
    .clk     (clk),
    .en_i    (cmd_fire),
    .we_i    (ram_we),
    .addr_i  (word_idx[IDX_W-1:0]),
    .wdata_i (bus.dtcm_cmd_wdata),
    .rdata_o (ram_rdata)
  );

  // State and response attributes. Reset drops any held response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rsp_read_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_read_q <= rsp_read_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next state. An accepted command always leaves a response behind.
  always_comb begin
    state_d    = state_q;
    rsp_read_d = rsp_read_q;
    rsp_err_d  = rsp_err_q;
    if (cmd_fire) begin
      rsp_read_d = bus.dtcm_cmd_read;
      rsp_err_d  = addr_err;
    end
    case (state_q)
      ST_IDLE: if (cmd_fire) state_d = ST_RSP;
      ST_RSP:  if (bus.dtcm_rsp_ready && !cmd_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs. The RAM read register only changes on accept, so data is stable under stall.
  always_comb begin
    bus.dtcm_rsp_valid = (state_q == ST_RSP);
    bus.dtcm_cmd_ready = (state_q == ST_IDLE) | bus.dtcm_rsp_ready;
    bus.dtcm_rsp_err   = (state_q == ST_RSP) & rsp_err_q;
    bus.dtcm_rsp_rdata = ((state_q == ST_RSP) && rsp_read_q && !rsp_err_q) ? ram_rdata : '0;
  end
endmodule

// File: tb/tb_dtcm_ctrl.sv
// tb_dtcm_ctrl: self-checking bench for dtcm_ctrl against a word-array model.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif

module tb_dtcm_ctrl;
  localparam int DP = 1024;
  localparam int AW = `DTCM_ADDR_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dtcm_ctrl_if #(.AW(AW)) bus ();
  dtcm_ctrl #(.DP(DP), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  rsp_t        pend_q[$];
  logic [31:0] model_mem [DP];

  int checks = 0;
  int failures = 0;

  logic        g_valid, g_ready, g_err, e_valid, e_ready, e_err;
  logic [31:0] g_rdata, e_rdata;

  function automatic rsp_t model_access(input bit rd, input logic [AW-1:0] a,
                                        input logic [31:0] wd, input logic [3:0] wm);
    rsp_t r;
    int   idx;
    idx     = int'(a) / 4;
    r.rdata = 32'h0;
    r.err   = 1'b0;
`ifdef DTCM_ADDR_CHK_EN
    if (idx >= DP) begin
      r.err = 1'b1;
      return r;
    end
`else
    idx = idx % DP;
`endif
    if (rd) r.rdata = model_mem[idx];
    else
      for (int b = 0; b < 4; b++)
        if (wm[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One clock: drive at posedge+1, sample at posedge+2, advance the model
  task automatic step(input bit v, input bit rd, input logic [AW-1:0] a,
                      input logic [31:0] wd, input logic [3:0] wm, input bit rr);
    bus.dtcm_cmd_valid = v;
    bus.dtcm_cmd_read  = rd;
    bus.dtcm_cmd_addr  = a;
    bus.dtcm_cmd_wdata = wd;
    bus.dtcm_cmd_wmask = wm;
    bus.dtcm_rsp_ready = rr;
    #1;
    g_valid = bus.dtcm_rsp_valid;
    g_ready = bus.dtcm_cmd_ready;
    g_rdata = bus.dtcm_rsp_rdata;
    g_err   = bus.dtcm_rsp_err;
    e_valid = (pend_q.size() != 0);
    e_ready = !e_valid || rr;
    e_rdata = e_valid ? pend_q[0].rdata : 32'h0;
    e_err   = e_valid ? pend_q[0].err : 1'b0;
    if (e_valid && rr) void'(pend_q.pop_front());
    if (v && e_ready) pend_q.push_back(model_access(rd, a, wd, wm));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.dtcm_cmd_valid = 1'b0;
    bus.dtcm_cmd_read  = 1'b0;
    bus.dtcm_cmd_addr  = '0;
    bus.dtcm_cmd_wdata = '0;
    bus.dtcm_cmd_wmask = '0;
    bus.dtcm_rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.dtcm_rsp_valid, bus.dtcm_rsp_err, bus.dtcm_rsp_rdata} !== 34'h0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b e=%b d=%h, want 0/0/0",
               bus.dtcm_rsp_valid, bus.dtcm_rsp_err, bus.dtcm_rsp_rdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.dtcm_cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready: got %b want 1", bus.dtcm_cmd_ready);
    end
    @(posedge clk);
    #1;
  endtask

  // Fill words 0..31 so later loads never hit unwritten RAM
  task automatic test_init;
    for (int i = 0; i <= 32; i++) begin
      if (i < 32) step(1'b1, 1'b0, AW'(4*i), $urandom, 4'hF, 1'b1);
      else        step(1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b1);
      checks++;
      if (g_valid !== e_valid || g_ready !== e_ready || (e_valid && (g_rdata !== e_rdata || g_err !== e_err))) begin
        failures++;
        $display("FAIL init[%0d]: got v=%b rdy=%b d=%h e=%b want v=%b rdy=%b d=%h e=%b",
                 i, g_valid, g_ready, g_rdata, g_err, e_valid, e_ready, e_rdata, e_err);
      end
    end
  endtask

  task automatic test_store_load;
    bit          v[3]  = '{1'b1, 1'b1, 1'b0};
    bit          rd[3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(v[i], rd[i], AW'(16'h0010), 32'hDEADBEEF, 4'hF, 1'b1);
      checks++;
      if (g_valid !== e_valid || g_ready !== e_ready || (e_valid && (g_rdata !== e_rdata || g_err !== e_err))) begin
        failures++;
        $display("FAIL store_load[%0d]: got v=%b rdy=%b d=%h e=%b want v=%b rdy=%b d=%h e=%b",
                 i, g_valid, g_ready, g_rdata, g_err, e_valid, e_ready, e_rdata, e_err);
      end
    end
    checks++;
    if (g_valid !== 1'b1 || g_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL store_load_value: got v=%b d=%h want 1 deadbeef", g_valid, g_rdata);
    end
  endtask

  task automatic test_byte_mask;
    bit          v[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit          rd[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] wd[7] = '{32'h11223344, 32'h00005500, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic [3:0]  wm[7] = '{4'hF, 4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 7; i++) begin
      step(v[i], rd[i], AW'(16'h0020), wd[i], wm[i], 1'b1);
      checks++;
      if (g_valid !== e_valid || g_ready !== e_ready || (e_valid && (g_rdata !== e_rdata || g_err !== e_err))) begin
        failures++;
        $display("FAIL byte_mask[%0d]: got v=%b rdy=%b d=%h e=%b want v=%b rdy=%b d=%h e=%b",
                 i, g_valid, g_ready, g_rdata, g_err, e_valid, e_ready, e_rdata, e_err);
      end
      if (i == 3 || i == 6) begin
        checks++;
        if (g_rdata !== 32'h11225544) begin
          failures++;
          $display("FAIL byte_mask_value[%0d]: got %h want 11225544", i, g_rdata);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] held;
    step(1'b1, 1'b1, AW'(16'h0010), 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i < 3)      step(1'b1, 1'b1, AW'(16'h0020), 32'h0, 4'h0, 1'b0);
      else if (i < 4) step(1'b1, 1'b1, AW'(16'h0020), 32'h0, 4'h0, 1'b1);
      else            step(1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b1);
      if (i == 0) held = g_rdata;
      checks++;
      if (g_valid !== e_valid || g_ready !== e_ready || (e_valid && (g_rdata !== e_rdata || g_err !== e_err))) begin
        failures++;
        $display("FAIL backpressure[%0d]: got v=%b rdy=%b d=%h e=%b want v=%b rdy=%b d=%h e=%b",
                 i, g_valid, g_ready, g_rdata, g_err, e_valid, e_ready, e_rdata, e_err);
      end
      if (i < 3) begin
        checks++;
        if (g_ready !== 1'b0 || g_valid !== 1'b1 || g_rdata !== held) begin
          failures++;
          $display("FAIL backpressure_hold[%0d]: got rdy=%b v=%b d=%h want 0 1 %h", i, g_ready, g_valid, g_rdata, held);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) step(1'b1, 1'b1, AW'(4*(i+4)), 32'h0, 4'h0, 1'b1);
      else       step(1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b1);
      if (g_valid === 1'b1) nvalid++;
      checks++;
      if (g_valid !== e_valid || g_ready !== e_ready || (e_valid && (g_rdata !== e_rdata || g_err !== e_err))) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got v=%b rdy=%b d=%h e=%b want v=%b rdy=%b d=%h e=%b",
                 i, g_valid, g_ready, g_rdata, g_err, e_valid, e_ready, e_rdata, e_err);
      end
    end
    checks++;
    if (nvalid != 4) begin
      failures++;
      $display("FAIL back_to_back_count: got %0d responses want 4", nvalid);
    end
  endtask

  task automatic test_addr_range;
    bit          v[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit          rd[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] a[4]  = '{16'h1000, 16'h1000, 16'h0000, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      step(v[i], rd[i], AW'(a[i]), 32'hA5A5_0F0F, 4'hF, 1'b1);
      checks++;
      if (g_valid !== e_valid || g_ready !== e_ready || (e_valid && (g_rdata !== e_rdata || g_err !== e_err))) begin
        failures++;
        $display("FAIL addr_range[%0d]: got v=%b rdy=%b d=%h e=%b want v=%b rdy=%b d=%h e=%b",
                 i, g_valid, g_ready, g_rdata, g_err, e_valid, e_ready, e_rdata, e_err);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] a;
      a = AW'(4*$urandom_range(0, 31) + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a + AW'(4*DP);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom,
           4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      checks++;
      if (g_valid !== e_valid || g_ready !== e_ready || (e_valid && (g_rdata !== e_rdata || g_err !== e_err))) begin
        failures++;
        $display("FAIL random[%0d]: got v=%b rdy=%b d=%h e=%b want v=%b rdy=%b d=%h e=%b",
                 i, g_valid, g_ready, g_rdata, g_err, e_valid, e_ready, e_rdata, e_err);
      end
    end
    step(1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b1);
  endtask

  task automatic test_reset_mid;
    step(1'b1, 1'b1, AW'(4*5), 32'h0, 4'h0, 1'b0);
    bus.dtcm_cmd_valid = 1'b0;
    bus.dtcm_rsp_ready = 1'b0;
    #1;
    checks++;
    if (bus.dtcm_rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pending: got v=%b want 1", bus.dtcm_rsp_valid);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.dtcm_rsp_valid, bus.dtcm_rsp_err, bus.dtcm_rsp_rdata} !== 34'h0) begin
      failures++;
      $display("FAIL reset_mid_async: got v=%b e=%b d=%h want 0/0/0",
               bus.dtcm_rsp_valid, bus.dtcm_rsp_err, bus.dtcm_rsp_rdata);
    end
    pend_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) step(1'b1, 1'b1, AW'(4*5), 32'h0, 4'h0, 1'b0);
      else        step(1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b1);
      checks++;
      if (g_valid !== e_valid || g_ready !== e_ready || (e_valid && (g_rdata !== e_rdata || g_err !== e_err))) begin
        failures++;
        $display("FAIL reset_mid_after[%0d]: got v=%b rdy=%b d=%h e=%b want v=%b rdy=%b d=%h e=%b",
                 i, g_valid, g_ready, g_rdata, g_err, e_valid, e_ready, e_rdata, e_err);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DP; i++) model_mem[i] = 32'h0;
    test_reset();
    test_init();
    test_store_load();
    test_byte_mask();
    test_backpressure();
    test_back_to_back();
    test_addr_range();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dtcm_ctrl.md
DTCM_CTRL -- requirements
Module: dtcm_ctrl

Interface
REQ-001 SHALL have parameter DP, default 1024, meaning the number of 32-bit words in the data TCM.
REQ-002 SHALL have parameter AW, default `DTCM_ADDR_WIDTH, meaning the byte-address width; word index = addr[AW-1:2].
REQ-003 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port dtcm_cmd_valid  input  1  command request from the LSU.
REQ-006 SHALL have port dtcm_cmd_ready  output  1  command accepted this cycle when high with valid.
REQ-007 SHALL have port dtcm_cmd_read  input  1  1 = load, 0 = store.
REQ-008 SHALL have port dtcm_cmd_addr  input  AW  byte address.
REQ-009 SHALL have port dtcm_cmd_wdata  input  `XLEN  store data.
REQ-010 SHALL have port dtcm_cmd_wmask  input  `XLEN/8  per-byte write enable.
REQ-011 SHALL have port dtcm_rsp_valid  output  1  response present.
REQ-012 SHALL have port dtcm_rsp_ready  input  1  LSU accepts the response.
REQ-013 SHALL have port dtcm_rsp_rdata  output  `XLEN  full aligned read word.
REQ-014 SHALL have port dtcm_rsp_err  output  1  address-range error (see Configuration).

Function
REQ-015 SHALL implement a two-state FSM: IDLE (no response held) and RSP (dtcm_rsp_valid=1).
REQ-016 SHALL drive dtcm_cmd_ready = (state==IDLE) | dtcm_rsp_ready, so at most one response is outstanding.
REQ-017 SHALL perform the RAM access in the cycle the command handshake occurs and present its response exactly 1 cycle later.
REQ-018 SHALL generate one response per accepted command, for loads and stores alike; store responses carry rdata = 0.
REQ-019 SHALL update only the bytes whose wmask bit is 1 on a store; wmask = 0 leaves the word unchanged but still responds.
REQ-020 SHALL ignore addr[1:0] for the RAM access; byte alignment and sign extension are the requester's job.
REQ-021 SHALL hold dtcm_rsp_valid, dtcm_rsp_rdata and dtcm_rsp_err stable while dtcm_rsp_valid=1 and dtcm_rsp_ready=0.
REQ-022 SHALL go from RSP to IDLE on rsp handshake without a new command, and stay in RSP when handshake and new command coincide (back-to-back, 1 response per cycle).
REQ-023 SHALL go from IDLE to RSP on cmd handshake.
REQ-024 SHALL return the new data for a load issued the cycle after a store to the same word (write commits at the store's accept edge).
REQ-025 SHALL never accept a command while in RSP with dtcm_rsp_ready=0.

Reset
REQ-026 SHALL, while rst=1, force state=IDLE, dtcm_rsp_valid=0, dtcm_rsp_rdata=0 and dtcm_rsp_err=0; dtcm_cmd_ready=1 after release.
REQ-027 SHALL drop a pending response on reset mid-operation; stores committed before reset assertion remain in RAM (RAM contents are not reset).

Configuration
REQ-028 SHALL, with macro DTCM_ADDR_CHK_EN defined, flag any word index >= DP with dtcm_rsp_err=1 and rdata=0, and suppress that store's write.
REQ-029 SHALL, without DTCM_ADDR_CHK_EN, tie dtcm_rsp_err to 0 and wrap the word index modulo DP (DP a power of two).

Structure
REQ-030 SHALL take XLEN and DTCM_ADDR_WIDTH from the shared defines.v; no new shared typedefs or constants.
REQ-031 SHALL instantiate one sub-module sram_1p, a single-port synchronous RAM with per-byte write enable and 1-cycle registered read, parameterised by depth and width.

Verification
REQ-032 Store addr 0x010, wdata 0xDEADBEEF, wmask 4'hF, then load 0x010 -> store rsp rdata=0, next cycle load rsp rdata=0xDEADBEEF.
REQ-033 Store 0x55 with wmask 4'b0010 to a word holding 0x11223344, then load -> rdata=0x11225544.
REQ-034 rsp_ready=0 for 3 cycles with a pending load -> rsp_valid and rdata stable, cmd_ready=0 throughout; first accepted cycle after rsp_ready=1 continues streaming.
REQ-035 Four back-to-back loads with rsp_ready=1 -> four responses in four consecutive cycles, in order, 1-cycle latency each.
REQ-036 With DTCM_ADDR_CHK_EN, DP=1024, store to 0x1000 then load 0x1000 -> both rsp_err=1, load rdata=0, word 0 unchanged; without the macro -> write lands in word 0.
REQ-037 Assert rst while in RSP -> rsp_valid=0 immediately (asynchronously); after release, cmd_ready=1 and previously written data is still readable.
